// File: rtl/map_table_pkg.sv
// map_table_pkg: shared sizing and types for the rename map table.
//   N_WAY     dispatch / CDB width (from `N_WAY when defined)
//   CDB_BITS  physical tag width (from `CDB_BITS when defined)
//   N_AREG    architectural registers, AREG_BITS index width
//   DN_W      width of the dispatch_num count
//   preg_t    physical tag type, areg_t architectural index type
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package map_table_pkg;
  localparam int N_WAY     = `N_WAY;
  localparam int CDB_BITS  = `CDB_BITS;
  localparam int N_AREG    = 32;
  localparam int AREG_BITS = 5;
  localparam int N_PREG    = 1 << CDB_BITS;
  localparam int DN_W      = $clog2(N_WAY) + 1;

  typedef logic [CDB_BITS-1:0]  preg_t;
  typedef logic [AREG_BITS-1:0] areg_t;
endpackage

// File: rtl/map_table_dep_check.sv
// rename_dep_check: intra-group dependency and Told priority logic.
// For every way it reports whether an earlier, valid way of the same
// dispatch group writes the register it reads (sources) or overwrites
// (Told), and which newly allocated tag must be forwarded instead of the
// committed map entry. The highest earlier way wins.
//   way_vld_i      way is part of the dispatch group
//   dest_areg_i    destination architectural registers
//   src1/2_areg_i  source architectural registers
//   free_tag_i     tags allocated to each way
//   src1/2_hit_o   source is produced earlier in the group
//   src1/2_fwd_o   forwarded tag for a hit source
//   told_hit_o     Told comes from the group, not from the map
//   told_fwd_o     forwarded Told tag
module rename_dep_check
  import map_table_pkg::*;
(
  input  logic  [N_WAY-1:0] way_vld_i,
  input  areg_t [N_WAY-1:0] dest_areg_i,
  input  areg_t [N_WAY-1:0] src1_areg_i,
  input  areg_t [N_WAY-1:0] src2_areg_i,
  input  preg_t [N_WAY-1:0] free_tag_i,
  output logic  [N_WAY-1:0] src1_hit_o,
  output preg_t [N_WAY-1:0] src1_fwd_o,
  output logic  [N_WAY-1:0] src2_hit_o,
  output preg_t [N_WAY-1:0] src2_fwd_o,
  output logic  [N_WAY-1:0] told_hit_o,
  output preg_t [N_WAY-1:0] told_fwd_o
);

  always_comb begin
    src1_hit_o = '0;
    src1_fwd_o = '0;
    src2_hit_o = '0;
    src2_fwd_o = '0;
    told_hit_o = '0;
    told_fwd_o = '0;
    for (int i = 0; i < N_WAY; i++) begin
      // Ascending scan: a later match overwrites, so the highest j wins.
      for (int j = 0; j < N_WAY; j++) begin
        if (j < i && way_vld_i[j] && dest_areg_i[j] != '0) begin
          if (dest_areg_i[j] == src1_areg_i[i]) begin
            src1_hit_o[i] = 1'b1;
            src1_fwd_o[i] = free_tag_i[j];
          end
          if (dest_areg_i[j] == src2_areg_i[i]) begin
            src2_hit_o[i] = 1'b1;
            src2_fwd_o[i] = free_tag_i[j];
          end
          if (dest_areg_i[j] == dest_areg_i[i]) begin
            told_hit_o[i] = 1'b1;
            told_fwd_o[i] = free_tag_i[j];
          end
        end
      end
      // An x0 destination hands its own unused tag back as Told.
      if (dest_areg_i[i] == '0) begin
        told_hit_o[i] = 1'b1;
        told_fwd_o[i] = free_tag_i[i];
      end
    end
  end

endmodule

// File: rtl/map_table.sv
// map_table: register-rename map table with per-tag ready bits.
// Renames up to N_WAY instructions per cycle using the tags offered by the
// free list, returns each destination's previous mapping (Told), tracks
// ready bits set by CDB broadcasts, and restores the retirement map on
// rollback. All outputs are combinational from state and inputs.
//   clock, reset        clock, synchronous active-high reset
//   dispatch_num        number of valid ways (0..dispatch_num-1)
//   dest/src1/src2_areg architectural registers per way
//   free_list_out       allocated tags per way
//   cdb_valid, cdb_tag  completion broadcasts
//   rollback, arch_map_in  recovery strobe and retirement map
//   src1/src2_preg/_ready  renamed sources and availability
//   dest_preg, told     new tag and previous mapping per way
module map_table
  import map_table_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [DN_W-1:0]     dispatch_num,
  input  areg_t [N_WAY-1:0]   dest_areg,
  input  areg_t [N_WAY-1:0]   src1_areg,
  input  areg_t [N_WAY-1:0]   src2_areg,
  input  preg_t [N_WAY-1:0]   free_list_out,
  input  logic  [N_WAY-1:0]   cdb_valid,
  input  preg_t [N_WAY-1:0]   cdb_tag,
  input  logic                rollback,
  input  preg_t [N_AREG-1:0]  arch_map_in,
  output preg_t [N_WAY-1:0]   src1_preg,
  output logic  [N_WAY-1:0]   src1_ready,
  output preg_t [N_WAY-1:0]   src2_preg,
  output logic  [N_WAY-1:0]   src2_ready,
  output preg_t [N_WAY-1:0]   dest_preg,
  output preg_t [N_WAY-1:0]   told
);

  preg_t [N_AREG-1:0] map_q, map_d;
  logic  [N_PREG-1:0] ready_q, ready_d;
  logic  [N_WAY-1:0]  way_vld;

  logic  [N_WAY-1:0]  src1_hit, src2_hit, told_hit;
  preg_t [N_WAY-1:0]  src1_fwd, src2_fwd, told_fwd;

  // Same-cycle CDB bypass for source readiness.
  function automatic logic cdb_match(input preg_t p);
    logic m;
    m = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      if (cdb_valid[k] && cdb_tag[k] == p) m = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      way_vld[i] = (DN_W'(i) < dispatch_num);
    end
  end

  rename_dep_check u_dep (
    .way_vld_i   (way_vld),
    .dest_areg_i (dest_areg),
    .src1_areg_i (src1_areg),
    .src2_areg_i (src2_areg),
    .free_tag_i  (free_list_out),
    .src1_hit_o  (src1_hit),
    .src1_fwd_o  (src1_fwd),
    .src2_hit_o  (src2_hit),
    .src2_fwd_o  (src2_fwd),
    .told_hit_o  (told_hit),
    .told_fwd_o  (told_fwd)
  );

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      dest_preg[i] = free_list_out[i];
      told[i]      = told_hit[i] ? told_fwd[i] : map_q[dest_areg[i]];

      if (src1_areg[i] == '0) begin
        src1_preg[i]  = '0;
        src1_ready[i] = 1'b1;
      end else if (src1_hit[i]) begin
        src1_preg[i]  = src1_fwd[i];
        src1_ready[i] = 1'b0;
      end else begin
        src1_preg[i]  = map_q[src1_areg[i]];
        src1_ready[i] = ready_q[src1_preg[i]] | cdb_match(src1_preg[i]);
      end

      if (src2_areg[i] == '0) begin
        src2_preg[i]  = '0;
        src2_ready[i] = 1'b1;
      end else if (src2_hit[i]) begin
        src2_preg[i]  = src2_fwd[i];
        src2_ready[i] = 1'b0;
      end else begin
        src2_preg[i]  = map_q[src2_areg[i]];
        src2_ready[i] = ready_q[src2_preg[i]] | cdb_match(src2_preg[i]);
      end
    end
  end

  // Next state: rollback replaces everything; otherwise CDB sets first and
  // allocation clears afterwards so a clear beats a set on the same tag.
  always_comb begin
    map_d   = map_q;
    ready_d = ready_q;
    if (rollback) begin
      map_d   = arch_map_in;
      ready_d = '1;
    end else begin
      for (int k = 0; k < N_WAY; k++) begin
        if (cdb_valid[k]) ready_d[cdb_tag[k]] = 1'b1;
      end
      for (int i = 0; i < N_WAY; i++) begin
        if (way_vld[i] && dest_areg[i] != '0) begin
          map_d[dest_areg[i]]       = free_list_out[i];
          ready_d[free_list_out[i]] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < N_AREG; a++) begin
        map_q[a] <= preg_t'(a);
      end
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
module tb_map_table;
  import map_table_pkg::*;

  logic               clock;
  logic               reset;
  logic [DN_W-1:0]    dispatch_num;
  areg_t [N_WAY-1:0]  dest_areg, src1_areg, src2_areg;
  preg_t [N_WAY-1:0]  free_list_out;
  logic  [N_WAY-1:0]  cdb_valid;
  preg_t [N_WAY-1:0]  cdb_tag;
  logic               rollback;
  preg_t [N_AREG-1:0] arch_map_in;
  preg_t [N_WAY-1:0]  src1_preg, src2_preg, dest_preg, told;
  logic  [N_WAY-1:0]  src1_ready, src2_ready;

  int n_vec = 0;
  int n_err = 0;

  map_table dut (
    .clock(clock), .reset(reset), .dispatch_num(dispatch_num),
    .dest_areg(dest_areg), .src1_areg(src1_areg), .src2_areg(src2_areg),
    .free_list_out(free_list_out), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rollback(rollback), .arch_map_in(arch_map_in),
    .src1_preg(src1_preg), .src1_ready(src1_ready),
    .src2_preg(src2_preg), .src2_ready(src2_ready),
    .dest_preg(dest_preg), .told(told)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    dispatch_num  = '0;
    dest_areg     = '0;
    src1_areg     = '0;
    src2_areg     = '0;
    free_list_out = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    rollback      = 1'b0;
    for (int a = 0; a < N_AREG; a++) arch_map_in[a] = preg_t'(a);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    dest_areg[0] = 5'd9;  dest_areg[1] = 5'd10; dest_areg[2] = 5'd11;
    src1_areg[0] = 5'd7;  src1_areg[1] = 5'd31;
    #1;
    n_vec++; if (told[0] !== 6'd9)  begin n_err++; $display("FAIL rst_told0 got %0d exp 9", told[0]); end
    n_vec++; if (told[1] !== 6'd10) begin n_err++; $display("FAIL rst_told1 got %0d exp 10", told[1]); end
    n_vec++; if (told[2] !== 6'd11) begin n_err++; $display("FAIL rst_told2 got %0d exp 11", told[2]); end
    n_vec++; if (src1_preg[0] !== 6'd7 || src1_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL rst_src1w0 got %0d/%0b exp 7/1", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src1_preg[1] !== 6'd31 || src1_ready[1] !== 1'b1)
      begin n_err++; $display("FAIL rst_src1w1 got %0d/%0b exp 31/1", src1_preg[1], src1_ready[1]); end
  endtask

  task automatic test_basic_rename();
    tick(); clear_inputs();
    dispatch_num = 3'd3;
    dest_areg[0] = 5'd1; dest_areg[1] = 5'd2; dest_areg[2] = 5'd3;
    free_list_out[0] = 6'd32; free_list_out[1] = 6'd33; free_list_out[2] = 6'd34;
    #1;
    n_vec++; if (told !== {6'd3, 6'd2, 6'd1})
      begin n_err++; $display("FAIL basic_told got %h exp told 3,2,1", told); end
    n_vec++; if (dest_preg !== {6'd34, 6'd33, 6'd32})
      begin n_err++; $display("FAIL basic_dest got %h exp 34,33,32", dest_preg); end
    tick(); clear_inputs();
    src1_areg[0] = 5'd1; src1_areg[1] = 5'd2;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd32 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL basic_x1 got %0d/%0b exp 32/0", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src1_preg[1] !== 6'd33 || src1_ready[1] !== 1'b0)
      begin n_err++; $display("FAIL basic_x2 got %0d/%0b exp 33/0", src1_preg[1], src1_ready[1]); end
  endtask

  task automatic test_chain();
    tick(); clear_inputs();
    dispatch_num = 3'd3;
    dest_areg[0] = 5'd5; free_list_out[0] = 6'd35;
    src1_areg[1] = 5'd5; dest_areg[1] = 5'd6; free_list_out[1] = 6'd37;
    dest_areg[2] = 5'd5; free_list_out[2] = 6'd36;
    #1;
    n_vec++; if (src1_preg[1] !== 6'd35 || src1_ready[1] !== 1'b0)
      begin n_err++; $display("FAIL chain_src got %0d/%0b exp 35/0", src1_preg[1], src1_ready[1]); end
    n_vec++; if (told[2] !== 6'd35) begin n_err++; $display("FAIL chain_told2 got %0d exp 35", told[2]); end
    n_vec++; if (told[0] !== 6'd5)  begin n_err++; $display("FAIL chain_told0 got %0d exp 5", told[0]); end
    tick(); clear_inputs();
    src1_areg[0] = 5'd5; src2_areg[0] = 5'd6;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd36 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL chain_map5 got %0d/%0b exp 36/0", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src2_preg[0] !== 6'd37 || src2_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL chain_map6 got %0d/%0b exp 37/0", src2_preg[0], src2_ready[0]); end
  endtask

  task automatic test_cdb();
    tick(); clear_inputs();
    src1_areg[0] = 5'd1; src2_areg[2] = 5'd2;
    cdb_valid = 3'b101; cdb_tag[0] = 6'd32; cdb_tag[2] = 6'd33;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd32 || src1_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL cdb_bypass0 got %0d/%0b exp 32/1", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src2_preg[2] !== 6'd33 || src2_ready[2] !== 1'b1)
      begin n_err++; $display("FAIL cdb_bypass2 got %0d/%0b exp 33/1", src2_preg[2], src2_ready[2]); end
    tick(); clear_inputs();
    src1_areg[0] = 5'd1;
    #1;
    n_vec++; if (src1_ready[0] !== 1'b1) begin n_err++; $display("FAIL cdb_held got %0b exp 1", src1_ready[0]); end
    // Reallocate tag 32 while lane 1 broadcasts it: the clear must win.
    dispatch_num = 3'd1; dest_areg[0] = 5'd8; free_list_out[0] = 6'd32;
    cdb_valid = 3'b010; cdb_tag[1] = 6'd32;
    tick(); clear_inputs();
    src1_areg[0] = 5'd8; src1_areg[1] = 5'd1;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd32 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL cdb_clrwin got %0d/%0b exp 32/0", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src1_preg[1] !== 6'd32 || src1_ready[1] !== 1'b0)
      begin n_err++; $display("FAIL cdb_clrx1 got %0d/%0b exp 32/0", src1_preg[1], src1_ready[1]); end
  endtask

  task automatic test_x0();
    tick(); clear_inputs();
    dispatch_num = 3'd2;
    dest_areg[0] = 5'd0; free_list_out[0] = 6'd40;
    src1_areg[1] = 5'd0; dest_areg[1] = 5'd7; free_list_out[1] = 6'd41;
    #1;
    n_vec++; if (told[0] !== 6'd40) begin n_err++; $display("FAIL x0_told got %0d exp 40", told[0]); end
    n_vec++; if (dest_preg[0] !== 6'd40) begin n_err++; $display("FAIL x0_dest got %0d exp 40", dest_preg[0]); end
    n_vec++; if (src1_preg[1] !== 6'd0 || src1_ready[1] !== 1'b1)
      begin n_err++; $display("FAIL x0_nofwd got %0d/%0b exp 0/1", src1_preg[1], src1_ready[1]); end
    n_vec++; if (told[1] !== 6'd7) begin n_err++; $display("FAIL x0_told1 got %0d exp 7", told[1]); end
    tick(); clear_inputs();
    src1_areg[0] = 5'd7; src2_areg[0] = 5'd0;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd41 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL x0_x7 got %0d/%0b exp 41/0", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src2_preg[0] !== 6'd0 || src2_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL x0_src got %0d/%0b exp 0/1", src2_preg[0], src2_ready[0]); end
  endtask

  task automatic test_rollback();
    tick(); clear_inputs();
    dispatch_num = 3'd1; dest_areg[0] = 5'd1; free_list_out[0] = 6'd50;
    tick(); clear_inputs();
    src1_areg[0] = 5'd1;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd50 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL rb_pre got %0d/%0b exp 50/0", src1_preg[0], src1_ready[0]); end
    rollback = 1'b1;
    dispatch_num = 3'd3;
    dest_areg[0] = 5'd1; dest_areg[1] = 5'd2; dest_areg[2] = 5'd3;
    free_list_out[0] = 6'd60; free_list_out[1] = 6'd61; free_list_out[2] = 6'd62;
    cdb_valid = 3'b001; cdb_tag[0] = 6'd50;
    tick(); clear_inputs();
    src1_areg[0] = 5'd1; src1_areg[1] = 5'd2; src1_areg[2] = 5'd3; src2_areg[0] = 5'd8;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd1 || src1_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL rb_x1 got %0d/%0b exp 1/1", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src1_preg[1] !== 6'd2 || src1_ready[1] !== 1'b1)
      begin n_err++; $display("FAIL rb_x2 got %0d/%0b exp 2/1", src1_preg[1], src1_ready[1]); end
    n_vec++; if (src1_preg[2] !== 6'd3 || src1_ready[2] !== 1'b1)
      begin n_err++; $display("FAIL rb_x3 got %0d/%0b exp 3/1", src1_preg[2], src1_ready[2]); end
    n_vec++; if (src2_preg[0] !== 6'd8 || src2_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL rb_x8 got %0d/%0b exp 8/1", src2_preg[0], src2_ready[0]); end
  endtask

  task automatic test_reset_mid();
    tick(); clear_inputs();
    dispatch_num = 3'd2;
    dest_areg[0] = 5'd4; free_list_out[0] = 6'd44;
    dest_areg[1] = 5'd5; free_list_out[1] = 6'd45;
    tick(); clear_inputs();
    src1_areg[0] = 5'd4;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd44 || src1_ready[0] !== 1'b0)
      begin n_err++; $display("FAIL rmid_pre got %0d/%0b exp 44/0", src1_preg[0], src1_ready[0]); end
    reset = 1'b1;
    rollback = 1'b1;
    for (int a = 0; a < N_AREG; a++) arch_map_in[a] = 6'd63;
    dispatch_num = 3'd3;
    dest_areg[0] = 5'd4; dest_areg[1] = 5'd5; dest_areg[2] = 5'd6;
    free_list_out[0] = 6'd46; free_list_out[1] = 6'd47; free_list_out[2] = 6'd48;
    cdb_valid = 3'b001; cdb_tag[0] = 6'd44;
    tick(); clear_inputs();
    reset = 1'b0;
    src1_areg[0] = 5'd4; src1_areg[1] = 5'd5; src1_areg[2] = 5'd6; src2_areg[0] = 5'd31;
    #1;
    n_vec++; if (src1_preg[0] !== 6'd4 || src1_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL rmid_x4 got %0d/%0b exp 4/1", src1_preg[0], src1_ready[0]); end
    n_vec++; if (src1_preg[1] !== 6'd5 || src1_ready[1] !== 1'b1)
      begin n_err++; $display("FAIL rmid_x5 got %0d/%0b exp 5/1", src1_preg[1], src1_ready[1]); end
    n_vec++; if (src1_preg[2] !== 6'd6 || src1_ready[2] !== 1'b1)
      begin n_err++; $display("FAIL rmid_x6 got %0d/%0b exp 6/1", src1_preg[2], src1_ready[2]); end
    n_vec++; if (src2_preg[0] !== 6'd31 || src2_ready[0] !== 1'b1)
      begin n_err++; $display("FAIL rmid_x31 got %0d/%0b exp 31/1", src2_preg[0], src2_ready[0]); end
  endtask

  initial begin
    test_reset();
    test_basic_rename();
    test_chain();
    test_cdb();
    test_x0();
    test_rollback();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
Register-rename map table for the N_WAY superscalar core. It sits directly downstream of the free list. Each cycle it consumes up to N_WAY free physical tags from free_list_out and renames the dispatch group's source and destination registers. It returns the previous mapping (Told) of each destination to the ROB; those tags come back to the free list as rob_told at retirement. It also tracks per-physical-register ready bits from CDB broadcasts and restores the architectural map on rollback.

Parameters:
N_WAY, 3, dispatch/CDB width (`N_WAY macro)
CDB_BITS, 6, physical tag width (`CDB_BITS macro), 2**CDB_BITS physical registers
N_AREG, 32, architectural registers (5-bit index)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
dispatch_num  in  $clog2(N_WAY)+1  ways dispatched this cycle (ways 0..dispatch_num-1 valid)
dest_areg  in  N_WAY x 5  destination architectural register per way
src1_areg  in  N_WAY x 5  source 1 architectural register per way
src2_areg  in  N_WAY x 5  source 2 architectural register per way
free_list_out  in  N_WAY x CDB_BITS  free physical tags from the free list, index 0 first
cdb_valid  in  N_WAY  CDB broadcast valid per lane
cdb_tag  in  N_WAY x CDB_BITS  completed physical tag per lane
rollback  in  1  mispredict recovery strobe
arch_map_in  in  N_AREG x CDB_BITS  retirement map used on rollback
src1_preg  out  N_WAY x CDB_BITS  renamed source 1
src1_ready  out  N_WAY  source 1 value available
src2_preg  out  N_WAY x CDB_BITS  renamed source 2
src2_ready  out  N_WAY  source 2 value available
dest_preg  out  N_WAY x CDB_BITS  newly allocated tag (= free_list_out[i])
told  out  N_WAY x CDB_BITS  previous mapping of dest, sent to the ROB

Behaviour:
- State: map[N_AREG] of CDB_BITS; ready[2**CDB_BITS] bits. Outputs are combinational from state and inputs in the same cycle. State updates on posedge clock.
- Reset (synchronous, checked first): map[i] = i; all ready = 1. Outputs follow reset state; with dispatch_num = 0, told/src equal the identity map.
- Allocation: way i < dispatch_num always takes free_list_out[i], so the free list pops exactly dispatch_num entries. dest_preg[i] = free_list_out[i].
- Told: told[i] = the latest mapping of dest_areg[i] from an earlier way j < i in the group, if any; otherwise map[dest_areg[i]].
- dest_areg == 0 (x0): map[0] is never written and stays 0. told[i] = free_list_out[i], so the unused tag is returned at retire. The ready bit for that tag is not cleared.
- Sources, per way i: if an earlier way j < i (j < dispatch_num, dest != 0) writes the same areg, take the highest such j. Then src_preg = free_list_out[j] and ready = 0. Otherwise src_preg = map[areg] and ready = ready[preg] OR any cdb_valid&&cdb_tag==preg (same-cycle bypass). Source x0 is always preg 0, ready 1.
- Map update: for ways i < dispatch_num with dest != 0, map[dest] <= free_list_out[i]. When several ways write the same areg, the highest way wins.
- Ready update: CDB lanes set ready[tag] <= 1. Allocation clears ready[free_list_out[i]] <= 0. If both target the same tag in one cycle, the clear wins.
- Rollback (priority below reset, above everything else): map <= arch_map_in; all ready <= 1; dispatch and CDB are ignored that cycle. Upstream must drive dispatch_num = 0 during rollback, and outputs are don't-care.
- Ways >= dispatch_num: outputs are don't-care and have no state effect.
- Reset mid-operation: reset overrides rollback and dispatch in the same cycle.

Decomposition:
- Shared package/header: the existing `N_WAY and `CDB_BITS macros, plus N_AREG, AREG_BITS=5, and a typedef preg_t = logic [CDB_BITS-1:0].
- One sub-module, rename_dep_check: the combinational intra-group dependency/Told priority logic per way, instantiated once. The map and ready-bit registers stay in the top module.

Test Plan:
- Reset, then dispatch_num=3 with dest x1,x2,x3 and free_list_out 32,33,34 -> told 1,2,3 and dest_preg 32,33,34. Next cycle src1 x1 -> src1_preg 32, src1_ready 0.
- Intra-group chain: dispatch_num=3, way0 dest x5 <- 35, way1 src1 x5, way2 dest x5 <- 36 -> way1 src1_preg 35 ready 0; way2 told 35; map[5] becomes 36 and told[0] = 5.
- CDB: cdb_valid[0]=1 with tag 32 in the same cycle as src x1 -> ready 1 (bypass). The next cycle without a CDB still shows ready 1. Allocating 32 with CDB 32 in the same cycle leaves ready[32] = 0.
- x0 destination: dispatch_num=1, dest x0, free 40 -> told 40, map[0] stays 0, and later src x0 gives preg 0, ready 1.
- Rollback after renaming x1 to 32: rollback=1 with arch_map_in identity -> next cycle src x1 gives preg 1, ready 1. CDB and dispatch in the rollback cycle have no effect.
- Reset asserted mid-stream while dispatch_num=3 and a CDB is valid -> next cycle the identity map is restored and all sources read ready 1.
